// File: rtl/tcm_arbiter.sv
// Three-port arbiter in front of tcm_controller: ibus, dbus and xbus share one TCM
// port through a combinational grant, with the response returned one cycle later.
`ifndef TCM_SIZE
`define TCM_SIZE 4096
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tcm_arbiter #(
    parameter int AW         = $clog2(`TCM_SIZE),
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [AW-1:0]             i_addr,
    input  logic                      i_w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] i_acc,
    input  logic [`BUS_WIDTH-1:0]     i_wdata,
    input  logic                      i_req,
    output logic [`BUS_WIDTH-1:0]     i_rdata,
    output logic                      i_resp,
    output logic                      i_fault,

    input  logic [AW-1:0]             d_addr,
    input  logic                      d_w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] d_acc,
    input  logic [`BUS_WIDTH-1:0]     d_wdata,
    input  logic                      d_req,
    output logic [`BUS_WIDTH-1:0]     d_rdata,
    output logic                      d_resp,
    output logic                      d_fault,

    input  logic [AW-1:0]             x_addr,
    input  logic                      x_w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] x_acc,
    input  logic [`BUS_WIDTH-1:0]     x_wdata,
    input  logic                      x_req,
    output logic [`BUS_WIDTH-1:0]     x_rdata,
    output logic                      x_resp,
    output logic                      x_fault,

    output logic [AW-1:0]             t_addr,
    output logic                      t_w_rb,
    output logic [`BUS_ACC_WIDTH-1:0] t_acc,
    output logic [`BUS_WIDTH-1:0]     t_wdata,
    output logic                      t_req,
    input  logic [`BUS_WIDTH-1:0]     t_rdata,
    input  logic                      t_resp,
    input  logic                      t_fault
);

    localparam logic [1:0] IDX_I = 2'd0;
    localparam logic [1:0] IDX_D = 2'd1;
    localparam logic [1:0] IDX_X = 2'd2;

    logic [2:0] req;
    logic [2:0] gnt;
    logic [2:0] gnt_d, gnt_q;
    logic       flt_d, flt_q;
    logic [1:0] last_d, last_q;

    // First requester found in the order a, b, c; returned one-hot.
    function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] c);
        logic [2:0] g;
        g = 3'b000;
        if (r[a])      g[a] = 1'b1;
        else if (r[b]) g[b] = 1'b1;
        else if (r[c]) g[c] = 1'b1;
        return g;
    endfunction

    assign req = {x_req, d_req, i_req};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        gnt = 3'b000;
        if (!rst) begin
            if (FIXED_PRIO) begin
                gnt = pick(req, IDX_D, IDX_X, IDX_I);
            end else begin
                case (last_q)
                    IDX_I:   gnt = pick(req, IDX_D, IDX_X, IDX_I);
                    IDX_D:   gnt = pick(req, IDX_X, IDX_I, IDX_D);
                    default: gnt = pick(req, IDX_I, IDX_D, IDX_X);
                endcase
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt[0])      last_d = IDX_I;
        else if (gnt[1]) last_d = IDX_D;
        else if (gnt[2]) last_d = IDX_X;
    end

    always_comb begin
        t_addr  = '0;
        t_w_rb  = 1'b0;
        t_acc   = '0;
        t_wdata = '0;
        if (gnt[0]) begin
            t_addr  = i_addr;
            t_w_rb  = i_w_rb;
            t_acc   = i_acc;
            t_wdata = i_wdata;
        end else if (gnt[1]) begin
            t_addr  = d_addr;
            t_w_rb  = d_w_rb;
            t_acc   = d_acc;
            t_wdata = d_wdata;
        end else if (gnt[2]) begin
            t_addr  = x_addr;
            t_w_rb  = x_w_rb;
            t_acc   = x_acc;
            t_wdata = x_wdata;
        end
    end

    assign t_req = (|gnt) & ~rst;
    assign gnt_d = gnt;
    assign flt_d = t_fault & t_req;

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q  <= 3'b000;
            flt_q  <= 1'b0;
            last_q <= IDX_X;
        end else begin
            gnt_q  <= gnt_d;
            flt_q  <= flt_d;
            last_q <= last_d;
        end
    end

    // The controller's response is registered, so returns depend only on flops and t_*.
    assign i_resp  = gnt_q[0] & t_resp;
    assign d_resp  = gnt_q[1] & t_resp;
    assign x_resp  = gnt_q[2] & t_resp;
    assign i_fault = gnt_q[0] & flt_q;
    assign d_fault = gnt_q[1] & flt_q;
    assign x_fault = gnt_q[2] & flt_q;
    assign i_rdata = t_rdata;
    assign d_rdata = t_rdata;
    assign x_rdata = t_rdata;

endmodule
